sd_sector_dma: RTL and testbench
================================

// Module: sd_sector_dma
// PURPOSE
//   Parametrised sector DMA engine between the SD byte stream and PDP-8 memory.
//   Packs and unpacks 12-bit words as 2 bytes per word, little-endian, upper nibble zero.
//   Buffers words in a small FIFO and moves them over the dmaREQ/dmaGNT memory port.
//   Supports full- and half-sector lengths. Sits between the RK8E sequencer and the sdspi byte engine.
// PARAMETERS
//   WORD_W        12    memory word width (bits); must be 9..16
//   ADDR_W        15    DMA address width (extended memory field + address)
//   SECTOR_WORDS  256   words per full sector; sector = 2*SECTOR_WORDS bytes
//   FIFO_DEPTH    4     word FIFO depth; power of 2, >=2
// PORTS
//   clk        in   1              system clock
//   reset      in   1              asynchronous, active-high reset
//   clear      in   1              synchronous abort (IOCLR)
//   start      in   1              begin transfer; sampled only in IDLE
//   opWRITE    in   1              0 = disk->memory, 1 = memory->disk
//   halfLEN    in   1              1 = move only SECTOR_WORDS/2 words
//   memADDR    in   ADDR_W         first memory address, latched on start
//   rxDATA     in   8              byte from SD (read path)
//   rxVALID    in   1              rxDATA valid
//   rxREADY    out  1              engine accepts rxDATA this cycle
//   txDATA     out  8              byte to SD (write path)
//   txVALID    out  1              txDATA valid
//   txREADY    in   1              SD accepts txDATA this cycle
//   dmaDIN     in   [0:WORD_W-1]   memory data into engine
//   dmaDOUT    out  [0:WORD_W-1]   data to memory
//   dmaADDR    out  [0:ADDR_W-1]   DMA address
//   dmaRD      out  1              memory read cycle
//   dmaWR      out  1              memory write cycle
//   dmaREQ     out  1              DMA request
//   dmaGNT     in   1              DMA grant
//   busy       out  1              transfer in progress
//   done       out  1              one-cycle pulse at normal completion
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, FIFO empty, counters 0.
//   States: IDLE -start-> RUN -all bytes moved and FIFO empty-> DONE -1 cycle-> IDLE.
//     - start while busy is ignored.
//   Limit L = halfLEN ? SECTOR_WORDS/2 : SECTOR_WORDS.
//     - Byte count is always 2*SECTOR_WORDS, whatever halfLEN is.
//   Memory handshake:
//     - One word moves in each cycle with dmaREQ & dmaGNT.
//     - dmaRD or dmaWR is asserted only together with dmaREQ.
//     - dmaADDR increments after each moved word, wrapping modulo 2^ADDR_W (all-ones -> 0).
//     - dmaREQ may drop between words; dmaGNT held high with dmaREQ low has no effect.
//   Read path (opWRITE=0):
//     - rxREADY = RUN & !FIFO full.
//     - Even byte -> word bits [8-bit LSBs]; odd byte low (WORD_W-8) bits -> MSBs; odd byte remaining bits ignored.
//     - Words with index < L are pushed to the FIFO; later words are consumed and discarded.
//     - dmaREQ = dmaWR = FIFO not empty; dmaDOUT = FIFO head.
//   Write path (opWRITE=1):
//     - dmaREQ = dmaRD = RUN & FIFO not full & words fetched < L.
//     - dmaDIN is captured in the grant cycle.
//     - txVALID when FIFO not empty or word index >= L; bytes with index >= L are 0x00 pad.
//     - Each word emits its LSB byte first, then its MSB byte (zero-extended).
//   FIFO:
//     - Simultaneous push and pop when full or empty is legal; occupancy is unchanged.
//     - Never overflows: producers are gated by !full.
//   done pulses in the DONE cycle; busy = RUN | DONE.
//   clear (any state) -> IDLE next cycle: FIFO flushed, outputs 0, no done pulse.
//   reset mid-transfer -> immediate IDLE: no done pulse, no partial words emitted.
// TESTING
//   1. Read, full: 512 bytes 0x55,0x0A repeating, dmaGNT=1 -> 256 dmaWR of 05125 to 0..0377; one done.
//   2. Read, halfLEN=1, memADDR=0100 -> 128 dmaWR (0100..0277); all 512 bytes consumed; done.
//   3. Write, full, dmaDIN=05252 -> txDATA 0xAA,0x0A x256 bytes-pairs; 256 dmaRD; done.
//   4. Write, halfLEN=1 -> 128 dmaRD; 256 data bytes then 256 bytes 0x00; total 512; done.
//   5. memADDR=077776, read, full -> addresses 077776, 077777, 00000, 00001, ...
//   6. Backpressure and aborts:
//      - random rxVALID/txREADY/dmaGNT gaps -> no data loss.
//      - clear at word 37 -> IDLE next cycle, no done.
//      - reset mid-transfer -> all outputs 0 immediately.

Source files
------------

// File: rtl/sd_sector_dma_if.sv
// Bus bundle for sd_sector_dma: control, SD byte stream (rx/tx) and the DMA memory port.
// The engine connects through the slave modport; the sequencer/SD/memory side uses the master modport.
interface sd_sector_dma_if #(
    parameter int WORD_W = 12,
    parameter int ADDR_W = 15
) ();
    logic                clear;
    logic                start;
    logic                opWRITE;
    logic                halfLEN;
    logic [0:ADDR_W-1]   memADDR;
    logic [7:0]          rxDATA;
    logic                rxVALID;
    logic                rxREADY;
    logic [7:0]          txDATA;
    logic                txVALID;
    logic                txREADY;
    logic [0:WORD_W-1]   dmaDIN;
    logic [0:WORD_W-1]   dmaDOUT;
    logic [0:ADDR_W-1]   dmaADDR;
    logic                dmaRD;
    logic                dmaWR;
    logic                dmaREQ;
    logic                dmaGNT;
    logic                busy;
    logic                done;

    modport slave (
        input  clear, start, opWRITE, halfLEN, memADDR,
        input  rxDATA, rxVALID, txREADY, dmaDIN, dmaGNT,
        output rxREADY, txDATA, txVALID, dmaDOUT, dmaADDR,
        output dmaRD, dmaWR, dmaREQ, busy, done
    );

    modport master (
        output clear, start, opWRITE, halfLEN, memADDR,
        output rxDATA, rxVALID, txREADY, dmaDIN, dmaGNT,
        input  rxREADY, txDATA, txVALID, dmaDOUT, dmaADDR,
        input  dmaRD, dmaWR, dmaREQ, busy, done
    );
endinterface

// File: rtl/sd_sector_dma.sv
// Sector DMA engine: packs SD bytes into memory words (read) or unpacks memory words
// into SD bytes (write), 2 bytes per word little-endian, through a small word FIFO.
module sd_sector_dma #(
    parameter int WORD_W       = 12,
    parameter int ADDR_W       = 15,
    parameter int SECTOR_WORDS = 256,
    parameter int FIFO_DEPTH   = 4
) (
    input logic           clk,
    input logic           reset,
    sd_sector_dma_if.slave bus
);
    localparam int BYTES = 2 * SECTOR_WORDS;
    localparam int CW    = $clog2(BYTES + 1);
    localparam int WCW   = CW - 1;
    localparam int PW    = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0]     BYTES_C  = CW'(BYTES);
    localparam logic [CW-1:0]     BYTE_ONE = CW'(1'b1);
    localparam logic [WCW-1:0]    FULL_L   = WCW'(SECTOR_WORDS);
    localparam logic [WCW-1:0]    HALF_L   = WCW'(SECTOR_WORDS / 2);
    localparam logic [WCW-1:0]    WORD_ONE = WCW'(1'b1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);
    localparam logic [PW:0]       DEPTH_C  = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0]       CNT_ONE  = (PW + 1)'(1'b1);
    localparam logic [PW-1:0]     PTR_ONE  = PW'(1'b1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_op;
    logic               r_half;
    logic               r_busy;
    logic               r_done;
    logic [ADDR_W-1:0]  r_addr;
    logic [CW-1:0]      r_byte_cnt;
    logic [WCW-1:0]     r_fetch_cnt;
    logic [7:0]         r_lo;
    logic [WORD_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PW-1:0]      r_wp;
    logic [PW-1:0]      r_rp;
    logic [PW:0]        r_cnt;

    logic               w_run;
    logic               w_start;
    logic               w_empty;
    logic               w_full;
    logic [WCW-1:0]     w_limit;
    logic [WCW-1:0]     w_word_idx;
    logic               w_bytes_left;
    logic               w_in_data;
    logic [WORD_W-1:0]  w_head;
    logic [7:0]         w_head_hi;
    logic               w_rx_ready;
    logic               w_rx_take;
    logic               w_tx_valid;
    logic               w_tx_take;
    logic               w_req;
    logic               w_xfer;
    logic               w_push;
    logic               w_pop;
    logic [WORD_W-1:0]  w_push_data;
    logic               w_finish;
    logic               w_rx_unused;

    assign w_run        = (r_state == S_RUN);
    assign w_start      = (r_state == S_IDLE) & bus.start;
    assign w_empty      = (r_cnt == '0);
    assign w_full       = (r_cnt == DEPTH_C);
    assign w_limit      = r_half ? HALF_L : FULL_L;
    assign w_word_idx   = r_byte_cnt[CW-1:1];
    assign w_bytes_left = (r_byte_cnt != BYTES_C);
    assign w_in_data    = (w_word_idx < w_limit);
    assign w_head       = r_mem[r_rp];
    assign w_head_hi    = 8'(w_head >> 4'd8);

    // The byte stream always covers a full sector; words past the limit are dropped or padded.
    assign w_rx_ready  = w_run & ~r_op & ~w_full & w_bytes_left;
    assign w_rx_take   = w_rx_ready & bus.rxVALID;
    assign w_tx_valid  = w_run & r_op & w_bytes_left & (~w_empty | ~w_in_data);
    assign w_tx_take   = w_tx_valid & bus.txREADY;
    assign w_req       = w_run & (r_op ? (~w_full & (r_fetch_cnt < w_limit)) : ~w_empty);
    assign w_xfer      = w_req & bus.dmaGNT;
    assign w_push      = r_op ? w_xfer : (w_rx_take & r_byte_cnt[0] & w_in_data);
    assign w_pop       = r_op ? (w_tx_take & r_byte_cnt[0] & w_in_data) : w_xfer;
    assign w_push_data = r_op ? WORD_W'(bus.dmaDIN) : {bus.rxDATA[WORD_W-9:0], r_lo};
    assign w_finish    = w_run & ~w_bytes_left & w_empty;
    assign w_rx_unused = ^bus.rxDATA;

    assign bus.rxREADY = w_rx_ready;
    assign bus.txVALID = w_tx_valid;
    assign bus.txDATA  = (w_tx_valid & w_in_data) ? (r_byte_cnt[0] ? w_head_hi : w_head[7:0]) : 8'h00;
    assign bus.dmaREQ  = w_req;
    assign bus.dmaRD   = w_req & r_op;
    assign bus.dmaWR   = w_req & ~r_op;
    assign bus.dmaADDR = w_req ? r_addr : '0;
    assign bus.dmaDOUT = (w_req & ~r_op) ? w_head : '0;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

    // Control FSM: sequencing, latched mode bits and the busy/done flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= 1'b0;
            r_half  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (bus.clear) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_op    <= bus.opWRITE;
                        r_half  <= bus.halfLEN;
                    end
                end
                S_RUN: begin
                    if (w_finish) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath counters, address, pending low byte and FIFO bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_byte_cnt  <= '0;
            r_fetch_cnt <= '0;
            r_lo        <= 8'h00;
            r_wp        <= '0;
            r_rp        <= '0;
            r_cnt       <= '0;
        end else if (bus.clear) begin
            r_addr      <= '0;
            r_byte_cnt  <= '0;
            r_fetch_cnt <= '0;
            r_lo        <= 8'h00;
            r_wp        <= '0;
            r_rp        <= '0;
            r_cnt       <= '0;
        end else begin
            if (w_start) begin
                r_addr      <= ADDR_W'(bus.memADDR);
                r_byte_cnt  <= '0;
                r_fetch_cnt <= '0;
            end else begin
                if (w_xfer) begin
                    r_addr <= r_addr + ADDR_ONE;
                end
                if (w_xfer & r_op) begin
                    r_fetch_cnt <= r_fetch_cnt + WORD_ONE;
                end
                if (w_rx_take | w_tx_take) begin
                    r_byte_cnt <= r_byte_cnt + BYTE_ONE;
                end
                if (w_rx_take & ~r_byte_cnt[0]) begin
                    r_lo <= bus.rxDATA;
                end
            end
            if (w_push) begin
                r_wp <= r_wp + PTR_ONE;
            end
            if (w_pop) begin
                r_rp <= r_rp + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the occupancy count is zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= w_push_data;
        end
    end
endmodule

// File: tb/tb_sd_sector_dma.sv
// Self-checking bench for sd_sector_dma: table of transfers with random stall patterns,
// compared against a sector-level reference model, plus clear/reset abort sequences.
module tb_sd_sector_dma;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    int          cur_pat;
    logic [11:0] cur_seed;

    sd_sector_dma_if #(.WORD_W(12), .ADDR_W(15)) bus ();

    sd_sector_dma #(
        .WORD_W(12), .ADDR_W(15), .SECTOR_WORDS(256), .FIFO_DEPTH(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] img(input logic [14:0] a, input int pat, input logic [11:0] seed);
        logic [11:0] r;
        if (pat == 0) begin
            r = 12'o5252;
        end else begin
            r = a[11:0] ^ {a[14:12], a[14:6]} ^ seed;
        end
        return r;
    endfunction

    // Memory model: the word at any address is a fixed function of that address.
    assign bus.dmaDIN = img(bus.dmaADDR, cur_pat, cur_seed);

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic        op;
        logic        half;
        logic [14:0] addr;
        int          pat;
        int          gap;
        int          exp_words;
        int          exp_first;
    } vec_t;

    function automatic logic rnd(input int gap);
        return (gap == 0) ? 1'b1 : ($urandom_range(0, 99) < 60);
    endfunction

    // abort: 0 = run to completion, 1 = clear after 37 words, 2 = reset mid-transfer
    task automatic run_xfer(input vec_t v, input int abort);
        logic [7:0]  rx_bytes [512];
        logic [14:0] exp_addr [$];
        logic [11:0] exp_data [$];
        logic [7:0]  exp_tx [$];
        logic [14:0] obs_addr [$];
        logic [11:0] obs_data [$];
        logic [7:0]  obs_tx [$];
        int rx_idx, done_cnt, proto_bad, lim, clr_cyc, mism;
        logic cleared;
        rx_idx = 0; done_cnt = 0; proto_bad = 0; cleared = 1'b0; clr_cyc = -100;
        cur_pat  = v.pat;
        cur_seed = 12'($urandom);
        lim = v.half ? 128 : 256;
        for (int i = 0; i < 512; i++) begin
            rx_bytes[i] = (v.pat == 0) ? ((i % 2 == 0) ? 8'h55 : 8'h0A) : 8'($urandom);
        end
        for (int i = 0; i < lim; i++) begin
            logic [14:0] a;
            logic [11:0] w;
            a = v.addr + 15'(i);
            exp_addr.push_back(a);
            if (v.op) begin
                w = img(a, v.pat, cur_seed);
                exp_tx.push_back(w[7:0]);
                exp_tx.push_back({4'h0, w[11:8]});
            end else begin
                exp_data.push_back({rx_bytes[2*i+1][3:0], rx_bytes[2*i]});
            end
        end
        while (exp_tx.size() < 512) exp_tx.push_back(8'h00);

        for (int cyc = 0; cyc < 6000; cyc++) begin
            logic stray;
            @(negedge clk);
            stray = (v.gap != 0) && (cyc == 50);
            bus.start   = (cyc == 0) || stray;
            bus.opWRITE = stray ? ~v.op : v.op;
            bus.halfLEN = stray ? ~v.half : v.half;
            bus.memADDR = stray ? ~v.addr : v.addr;
            bus.clear   = (abort == 1) && !cleared && (obs_addr.size() == 37);
            bus.rxVALID = !v.op && (rx_idx < 512) && rnd(v.gap);
            bus.rxDATA  = bus.rxVALID ? rx_bytes[rx_idx] : 8'h00;
            bus.txREADY = rnd(v.gap);
            bus.dmaGNT  = rnd(v.gap);
            #1;
            if (bus.clear) begin
                cleared = 1'b1;
                clr_cyc = cyc;
            end else begin
                if (bus.rxVALID && bus.rxREADY) rx_idx++;
                if (bus.txVALID && bus.txREADY) obs_tx.push_back(bus.txDATA);
                if (bus.dmaREQ && bus.dmaGNT) begin
                    obs_addr.push_back(bus.dmaADDR);
                    obs_data.push_back(bus.dmaDOUT);
                end
                if ((bus.dmaRD || bus.dmaWR) && !bus.dmaREQ) proto_bad++;
                if (bus.dmaRD && bus.dmaWR) proto_bad++;
                if (bus.done) done_cnt++;
            end
            if (cleared && cyc == clr_cyc + 1) begin
                chk("clear_idle_busy", bus.busy, 0);
                chk("clear_idle_outs", {bus.rxREADY, bus.dmaREQ, bus.dmaWR, bus.txVALID}, 0);
            end
            if (cleared && cyc == clr_cyc + 20) break;
            if (abort == 2 && cyc == 100) begin
                chk("pre_reset_busy", bus.busy, 1);
                reset = 1'b1;
                #1;
                chk("reset_outs_zero", {bus.rxREADY, bus.txVALID, bus.dmaREQ, bus.dmaRD, bus.dmaWR,
                                        bus.busy, bus.done, |bus.dmaADDR, |bus.dmaDOUT, |bus.txDATA}, 0);
                repeat (3) begin
                    @(negedge clk);
                    if (bus.done) done_cnt++;
                end
                reset = 1'b0;
                break;
            end
            if (abort == 0 && done_cnt > 0) break;
        end
        bus.start = 1'b0; bus.clear = 1'b0; bus.rxVALID = 1'b0;

        if (abort == 1) begin
            chk("clear_no_done", done_cnt, 0);
            chk("clear_words", obs_addr.size(), 37);
        end else if (abort == 2) begin
            chk("reset_no_done", done_cnt, 0);
        end else begin
            chk("done_pulses", done_cnt, 1);
            chk("dma_words", obs_addr.size(), v.exp_words);
            chk("first_addr", (obs_addr.size() > 0) ? obs_addr[0] : -1, v.exp_first);
            mism = 0;
            for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
                if (obs_addr[i] !== exp_addr[i]) mism++;
                if (!v.op && obs_data[i] !== exp_data[i]) mism++;
            end
            chk(v.op ? "rd_addr_seq" : "wr_addr_data_seq", mism, 0);
            if (v.op) begin
                chk("tx_byte_count", obs_tx.size(), 512);
                mism = 0;
                for (int i = 0; i < obs_tx.size() && i < 512; i++) begin
                    if (obs_tx[i] !== exp_tx[i]) mism++;
                end
                chk("tx_bytes", mism, 0);
            end else begin
                chk("rx_consumed", rx_idx, 512);
            end
            chk("protocol", proto_bad, 0);
            @(negedge clk);
            #1;
            chk("busy_after", bus.busy, 0);
        end
    endtask

    initial begin
        vec_t vecs [9];
        total = 0; bad = 0; cur_pat = 0; cur_seed = 12'h000;
        clk = 1'b0; reset = 1'b1;
        bus.clear = 1'b0; bus.start = 1'b0; bus.opWRITE = 1'b0; bus.halfLEN = 1'b0;
        bus.memADDR = '0; bus.rxDATA = 8'h00; bus.rxVALID = 1'b0; bus.txREADY = 1'b0;
        bus.dmaGNT = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 15'o00000, 0, 0, 256, 15'o00000};
        vecs[1] = '{1'b0, 1'b1, 15'o00100, 1, 0, 128, 15'o00100};
        vecs[2] = '{1'b1, 1'b0, 15'o00000, 0, 0, 256, 15'o00000};
        vecs[3] = '{1'b1, 1'b1, 15'o00200, 1, 0, 128, 15'o00200};
        vecs[4] = '{1'b0, 1'b0, 15'o77776, 1, 0, 256, 15'o77776};
        vecs[5] = '{1'b0, 1'b0, 15'o12345, 1, 1, 256, 15'o12345};
        vecs[6] = '{1'b1, 1'b0, 15'o77700, 1, 1, 256, 15'o77700};
        vecs[7] = '{1'b0, 1'b1, 15'o00000, 1, 1, 128, 15'o00000};
        vecs[8] = '{1'b1, 1'b1, 15'o77770, 1, 1, 128, 15'o77770};

        repeat (3) @(negedge clk);
        chk("reset_state", {bus.rxREADY, bus.txVALID, bus.dmaREQ, bus.dmaRD, bus.dmaWR,
                            bus.busy, bus.done, |bus.dmaADDR, |bus.dmaDOUT, |bus.txDATA}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", {bus.busy, bus.done, bus.dmaREQ, bus.rxREADY}, 0);

        for (int i = 0; i < 9; i++) run_xfer(vecs[i], 0);
        run_xfer(vecs[5], 1);
        run_xfer(vecs[0], 0);
        run_xfer(vecs[6], 2);
        run_xfer(vecs[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
